// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the iterative multiply/divide unit.
//   - MD_* : 3-bit operation codes carried on the muldiv_seq op port.
//   - mag32: conditional two's-complement negation, used both to take an
//            operand magnitude and to restore the sign of a result.
package muldiv_seq_pkg;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
      return neg ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-cycle iterative multiply / divide unit for the EX stage.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   start  - request strobe (accepted in IDLE or DONE)
//   op     - MD_MUL .. MD_REMU
//   A, B   - operands rs1 / rs2
//   flush  - abort any operation, return to IDLE without a done pulse
//   stall  - holds IF/ID/EX while an operation is being accepted or computed
//   busy   - high while iterating
//   done   - one-cycle result-valid pulse
//   result - selected result word, held until the next accepted start
module muldiv_seq
   import muldiv_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [2:0]  op_r;
   logic [31:0] opb;      // magnitude of B (multiplicand / divisor)
   logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic        neg_q;    // product or quotient must be negated
   logic        neg_r;    // remainder must be negated

   logic        is_div, a_sgn, b_sgn, neg_a, neg_b;
   logic        div_zero, div_ovf, fast;
   logic [31:0] fast_res;
   logic [32:0] sum, shifted, diff;
   logic [63:0] acc_nxt, prod;
   logic [31:0] quo, rem, fin;

   // Operand decode for the request presented this cycle
   always_comb begin
      is_div   = op[2];
      a_sgn    = is_div ? ~op[0] : (op != MD_MULHU);
      b_sgn    = is_div ? ~op[0] : ((op == MD_MUL) || (op == MD_MULH));
      neg_a    = a_sgn & A[31];
      neg_b    = b_sgn & B[31];
      div_zero = is_div && (B == 32'd0);
      div_ovf  = is_div && !op[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
      fast     = div_zero || div_ovf;
      // op[1] separates REM/REMU from DIV/DIVU
      if (div_zero)
         fast_res = op[1] ? A : 32'hFFFF_FFFF;
      else
         fast_res = op[1] ? 32'd0 : 32'h8000_0000;
   end

   // One shift-add or restoring-subtract step, plus sign fix-up of its outcome
   always_comb begin
      sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
      shifted = acc[63:31];
      diff    = shifted - {1'b0, opb};
      if (op_r[2])
         // A negative difference (bit 32 set) restores the shifted remainder
         acc_nxt = diff[32] ? {shifted[31:0], acc[30:0], 1'b0}
                            : {diff[31:0],    acc[30:0], 1'b1};
      else
         acc_nxt = {sum, acc[31:1]};
      prod = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
      quo  = mag32(acc_nxt[31:0], neg_q);
      rem  = mag32(acc_nxt[63:32], neg_r);
      case (op_r)
         MD_MUL:                       fin = prod[31:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fin = prod[63:32];
         MD_DIV, MD_DIVU:              fin = quo;
         default:                      fin = rem;
      endcase
   end

   always_comb begin
      stall = (start && ((state == IDLE) || (state == DONE))) || (state == CALC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         op_r   <= 3'd0;
         opb    <= 32'd0;
         acc    <= 64'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= 32'd0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= 5'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_r  <= op;
                  opb   <= mag32(B, neg_b);
                  acc   <= {32'd0, mag32(A, neg_a)};
                  neg_q <= neg_a ^ neg_b;
                  neg_r <= neg_a;
                  cnt   <= 5'd0;
                  if (fast) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= fast_res;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= fin;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq. Stimulus pushes the
// hand-computed result and the cycle at which done must appear; a monitor
// pops and compares on every done pulse.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        flush = 1'b0;
   logic        stall, busy, done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   stall_cnt = 0;
   int   done_cnt = 0;

   muldiv_seq dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
      .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (stall) stall_cnt <= stall_cnt + 1;

   // Monitor
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_cnt = done_cnt + 1;
         checks = checks + 1;
         if (q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_done: result=%h at cycle %0d, none required", result, cyc);
         end else begin
            e = q.pop_front();
            if (result !== e.res) begin
               errors = errors + 1;
               $display("FAIL result: got %h, required %h", result, e.res);
            end
            checks = checks + 1;
            if (cyc != e.cyc) begin
               errors = errors + 1;
               $display("FAIL latency: done at cycle %0d, required %0d", cyc, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   // Called at posedge+1: request is taken at the coming edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat);
      exp_t e;
      start = 1'b1; op = o; A = a; B = b;
      e.res = r; e.cyc = cyc + lat;
      q.push_back(e);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout: %0d results still outstanding", q.size());
         q.delete();
      end
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input int lat);
      @(posedge clk); #1;
      issue(o, a, b, r, lat);
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(60);
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   {31'd0, busy},  32'd0);
      check("reset_done",   {31'd0, done},  32'd0);
      check("reset_stall",  {31'd0, stall}, 32'd0);
      check("reset_result", result,         32'd0);
      rst = 1'b0;

      // MUL with stall window measurement
      @(posedge clk); #1;
      stall_cnt = 0;
      issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(60);
      repeat (3) @(posedge clk);
      #1;
      check("mul_stall_cycles", stall_cnt, 32'd33);

      run(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
      run(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run(MD_DIVU,   32'd7,         32'd2,         32'd3,         33);
      run(MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      run(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run(MD_REMU,   32'd9,         32'd0,         32'd9,         1);

      // Flush during CALC cycle 10
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; op = MD_DIVU; A = 32'd1000; B = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("busy_before_flush", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check("flush_no_done", done_cnt - d0, 32'd0);

      // Reset mid-CALC
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; op = MD_MUL; A = 32'd3; B = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_busy",   {31'd0, busy},  32'd0);
      check("rst_done",   {31'd0, done},  32'd0);
      check("rst_stall",  {31'd0, stall}, 32'd0);
      check("rst_result", result,         32'd0);
      repeat (40) @(posedge clk);
      #1;
      check("rst_no_done", done_cnt - d0, 32'd0);

      // Back-to-back: start held through CALC (ignored) and DONE (accepted)
      @(posedge clk); #1;
      issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
      @(posedge clk); #1;
      op = MD_REMU; A = 32'hDEAD_BEEF; B = 32'd1;
      repeat (32) @(posedge clk);
      #1;
      issue(MD_MUL, 32'd6, 32'd7, 32'd42, 33);
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(80);
      repeat (2) @(posedge clk);
      #1;
      check("final_result_hold", result, 32'd42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request strobe from the EX stage.
REQ-004 SHALL have port op, input, 3 bits: selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-005 SHALL have port A, input, 32 bits: operand rs1.
REQ-006 SHALL have port B, input, 32 bits: operand rs2.
REQ-007 SHALL have port flush, input, 1 bit: pipeline flush; aborts any operation.
REQ-008 SHALL have port stall, output, 1 bit: freezes IF/ID/EX while the operation is pending.
REQ-009 SHALL have port busy, output, 1 bit: high while the FSM is in CALC.
REQ-010 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have port result, output, 32 bits: the selected result word.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL, when start=1 in IDLE or DONE at edge N, latch op, A and B, and:
- go to CALC with iteration count 0 (normal case), or
- go to DONE (fast path).
REQ-014 SHALL ignore start while in CALC; latched operands are unaffected.
REQ-015 SHALL, in CALC, perform one iteration per cycle on operand magnitudes:
- multiply: shift-add into a 64-bit product;
- divide: restoring subtract into a 32-bit quotient and 32-bit remainder.
REQ-016 SHALL leave CALC for DONE after exactly 32 iterations, so done=1 during the cycle after edge N+32.
REQ-017 SHALL apply sign correction as follows:
- MUL/MULH treat both operands as signed; MULHSU treats A signed and B unsigned; MULHU treats both unsigned.
- The product is negated when the operand signs differ.
- The quotient sign is A xor B; the remainder takes the sign of A.
REQ-018 SHALL select the result word: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-019 SHALL take the fast path (done=1 during the cycle after edge N) for:
- divide by zero: quotient 0xFFFFFFFF, remainder = A;
- signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-020 SHALL assert done only in DONE.
REQ-021 SHALL hold result stable from DONE until the next accepted start.
REQ-022 SHALL move from DONE to IDLE when start=0.
REQ-023 SHALL drive stall combinationally as (start AND state in {IDLE, DONE}) OR (state==CALC), and SHALL drive stall=0 in DONE without start so the pipeline captures the result.
REQ-024 SHALL, on flush=1 in any state, enter IDLE on the next edge with no done pulse; flush SHALL override a simultaneous start.
REQ-025 SHALL perform all arithmetic in unsigned widths with explicit sign handling: 33-bit partial remainder, 64-bit product.

Reset
REQ-026 SHALL, when rst=1 at an edge, enter IDLE and clear the iteration counter, busy, done, result and internal registers to 0.
REQ-027 SHALL let reset override flush and start, including mid-CALC; no done pulse SHALL follow reset.

Structure
REQ-028 SHALL add the op encodings MD_MUL..MD_REMU (3'd0..3'd7) as macros to ctrl_encode_def.v beside the ALU_* codes.
REQ-029 SHALL keep the FSM state encodings local to the module.
REQ-030 SHALL be a single module with no sub-module; the existing ALU SHALL NOT be reused for the iterative step.

Verification
REQ-031 SHALL cover: MUL A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB, done 33 cycles after start, stall high for exactly those 33 cycles.
REQ-032 SHALL cover: MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=7, B=2 -> 3.
REQ-034 SHALL cover: DIVU A=5, B=0 -> 0xFFFFFFFF with done the next cycle; REM A=0x80000000, B=0xFFFFFFFF -> 0 with done the next cycle.
REQ-035 SHALL cover: flush in CALC cycle 10 -> busy=0 next cycle, no done; rst mid-CALC -> all outputs 0 next cycle.
REQ-036 SHALL cover: start held high in DONE -> back-to-back operation accepted, second result correct, start during CALC ignored.
